// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - sparse convolution pass sequencer driving a single mac_16bit
module mac_sequencer #(
    parameter int NON_ZERO_WEIGHTS = 27,
    parameter int NUM_OUTPUTS      = 256,
    parameter int ADDR_W           = 16,
    parameter int RESULT_LATENCY   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_act_base,
    input  logic [ADDR_W-1:0] cfg_out_base,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [15:0]       w_data,
    input  logic [ADDR_W-1:0] off_data,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [15:0]       a_data,
    output logic [15:0]       mac_md,
    output logic [15:0]       mac_mr,
    output logic              mac_rst,
    input  logic [26:0]       mac_out,
    output logic [26:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam int TOTAL = NON_ZERO_WEIGHTS * NUM_OUTPUTS;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int KW    = $clog2(NON_ZERO_WEIGHTS + 1);
    localparam int OW    = $clog2(NUM_OUTPUTS + 1);
    localparam int L     = RESULT_LATENCY;

    localparam logic [KW-1:0] K_LAST  = KW'(NON_ZERO_WEIGHTS - 1);
    localparam logic [CW-1:0] C_TOTAL = CW'(TOTAL);
    localparam logic [OW-1:0] O_TOTAL = OW'(NUM_OUTPUTS);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state;
    logic [KW-1:0]     k;
    logic [ADDR_W-1:0] p;
    logic [CW-1:0]     cnt;
    logic [OW-1:0]     og;
    logic [ADDR_W-1:0] act_base;
    logic [ADDR_W-1:0] out_base;

    logic              v0, v1, v2, v3;
    logic              last0, last1, last2, last3;
    logic [ADDR_W-1:0] p0, p1;
    logic [15:0]       wd1, wd2;
    logic [L-1:0]      dl;

    logic [KW-1:0]     k_cur;
    logic [ADDR_W-1:0] p_cur;
    logic              k_end;
    logic              issue;

    // The start cycle itself issues operand (0,0), so k/p always hold the next pair to issue.
    always_comb begin
        k_cur = '0;
        p_cur = '0;
        if (state != IDLE) begin
            k_cur = k;
            p_cur = p;
        end
        k_end = (k_cur == K_LAST);
        issue = (state == IDLE && start) || (state == ISSUE && cnt != C_TOTAL);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            k         <= '0;
            p         <= '0;
            cnt       <= '0;
            og        <= '0;
            act_base  <= '0;
            out_base  <= '0;
            v0        <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            last0     <= 1'b0;
            last1     <= 1'b0;
            last2     <= 1'b0;
            last3     <= 1'b0;
            p0        <= '0;
            p1        <= '0;
            wd1       <= '0;
            wd2       <= '0;
            dl        <= '0;
            w_addr    <= '0;
            a_addr    <= '0;
            mac_md    <= '0;
            mac_mr    <= '0;
            mac_rst   <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            v0    <= issue;
            last0 <= issue && k_end;
            if (issue) begin
                w_addr <= ADDR_W'(k_cur);
                p0     <= p_cur;
                k      <= k_end ? '0 : k_cur + KW'(1);
                p      <= k_end ? p_cur + ADDR_W'(1) : p_cur;
                cnt    <= (state == IDLE) ? CW'(1) : cnt + CW'(1);
            end

            // ROM data valid: build activation address from the aligned pixel index
            v1    <= v0;
            last1 <= last0;
            p1    <= p0;
            v2    <= v1;
            last2 <= last1;
            if (v1)
                a_addr <= act_base + p1 + off_data;
            wd1   <= w_data;
            wd2   <= wd1;
            v3    <= v2;
            last3 <= last2;

            mac_md <= v3 ? a_data : '0;
            mac_mr <= v3 ? wd2 : '0;

            // dl[0] lines up with the group's last operand on the MAC inputs
            dl[0] <= v3 && last3;
            for (int i = 1; i < L; i++)
                dl[i] <= dl[i-1];

            out_valid <= dl[L-1];
            if (dl[L-1]) begin
                out_data <= mac_out;
                out_addr <= out_base + ADDR_W'(og);
                og       <= og + OW'(1);
            end

            done <= 1'b0;
            case (state)
                IDLE: begin
                    mac_rst <= 1'b0;
                    if (start) begin
                        state    <= ISSUE;
                        busy     <= 1'b1;
                        act_base <= cfg_act_base;
                        out_base <= cfg_out_base;
                        og       <= '0;
                    end
                end
                ISSUE: begin
                    if (v2)
                        mac_rst <= 1'b1;
                    if (cnt == C_TOTAL)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (v2)
                        mac_rst <= 1'b1;
                    if (out_valid && og == O_TOTAL) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        mac_rst <= 1'b0;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    mac_rst <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - directed bench for mac_sequencer with ROM/RAM/MAC stand-ins
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc_abs = 0;
    logic [26:0] mac_out;

    logic        start1 = 1'b0, start4 = 1'b0;
    logic [15:0] cfg1_act = '0, cfg1_out = '0, cfg4_act = '0, cfg4_out = '0;
    logic [15:0] w_addr1, a_addr1, oa1, w_addr4, a_addr4, oa4;
    logic [15:0] w_data1 = '0, off1 = '0, a_data1 = '0;
    logic [15:0] w_data4 = '0, off4 = '0, a_data4 = '0;
    logic [15:0] md1, mr1, md4, mr4;
    logic [26:0] od1, od4;
    logic        mrst1, ov1, busy1, done1, mrst4, ov4, busy4, done4;

    int checks = 0;
    int failures = 0;
    int c;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_abs <= cyc_abs + 1;
    assign mac_out = 27'(cyc_abs * 3 + 7);

    // Weight = k+1, offset = k, activation = address ^ 0xA5A5; all 1-cycle reads
    always @(posedge clk) begin
        w_data1 <= w_addr1 + 16'd1;
        off1    <= w_addr1;
        a_data1 <= a_addr1 ^ 16'hA5A5;
        w_data4 <= w_addr4 + 16'd1;
        off4    <= w_addr4;
        a_data4 <= a_addr4 ^ 16'hA5A5;
    end

    mac_sequencer #(.NON_ZERO_WEIGHTS(27), .NUM_OUTPUTS(1), .ADDR_W(16), .RESULT_LATENCY(5)) u1 (
        .clk(clk), .rst(rst), .start(start1), .cfg_act_base(cfg1_act), .cfg_out_base(cfg1_out),
        .w_addr(w_addr1), .w_data(w_data1), .off_data(off1), .a_addr(a_addr1), .a_data(a_data1),
        .mac_md(md1), .mac_mr(mr1), .mac_rst(mrst1), .mac_out(mac_out), .out_data(od1),
        .out_addr(oa1), .out_valid(ov1), .busy(busy1), .done(done1)
    );

    mac_sequencer #(.NON_ZERO_WEIGHTS(27), .NUM_OUTPUTS(4), .ADDR_W(16), .RESULT_LATENCY(5)) u4 (
        .clk(clk), .rst(rst), .start(start4), .cfg_act_base(cfg4_act), .cfg_out_base(cfg4_out),
        .w_addr(w_addr4), .w_data(w_data4), .off_data(off4), .a_addr(a_addr4), .a_data(a_data4),
        .mac_md(md4), .mac_mr(mr4), .mac_rst(mrst4), .mac_out(mac_out), .out_data(od4),
        .out_addr(oa4), .out_valid(ov4), .busy(busy4), .done(done4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One NUM_OUTPUTS=1 pass on u1; cycle c is sampled 1 time unit after its opening edge.
    task automatic run_single(input logic [15:0] abase, input logic [15:0] obase, input bit poke);
        logic [26:0] exp_od;
        logic [15:0] ea;
        exp_od   = '0;
        cfg1_act = abase;
        cfg1_out = obase;
        start1   = 1'b1;
        c = 0;
        tick();
        start1   = 1'b0;
        cfg1_act = ~abase;
        cfg1_out = ~obase;
        for (c = 1; c <= 38; c++) begin
            check("busy", 32'(busy1), 32'(c <= 36));
            check("mac_rst", 32'(mrst1), 32'(c >= 4 && c <= 36));
            check("out_valid", 32'(ov1), 32'(c == 36));
            check("done", 32'(done1), 32'(c == 37));
            if (c >= 3 && c <= 29) begin
                ea = abase + 16'(c - 3);
                check("a_addr", 32'(a_addr1), 32'(ea));
            end
            if (c >= 5 && c <= 31) begin
                ea = (abase + 16'(c - 5)) ^ 16'hA5A5;
                check("mac_mr", 32'(mr1), 32'(c - 4));
                check("mac_md", 32'(md1), 32'(ea));
            end
            if (c == 35)
                exp_od = 27'((cyc_abs) * 3 + 7);
            if (c == 36) begin
                check("out_addr", 32'(oa1), 32'(obase));
                check("out_data", 32'(od1), 32'(exp_od));
            end
            start1 = poke && (c == 10 || c == 33);
            tick();
        end
        start1 = 1'b0;
    endtask

    initial begin
        int seen;
        logic [15:0] ea;
        start1 = 1'b1;
        start4 = 1'b1;
        repeat (3) tick();
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_mac_rst", 32'(mrst1), 32'd0);
        check("rst_w_addr", 32'(w_addr1), 32'd0);
        check("rst_a_addr", 32'(a_addr1), 32'd0);
        check("rst_mac_md_mr", 32'({md1, mr1}), 32'd0);
        check("rst_out", 32'({ov1, done1, od1}), 32'd0);
        check("rst_out_addr", 32'(oa1), 32'd0);
        check("rst_u4", 32'({busy4, mrst4, ov4, done4}), 32'd0);
        rst    = 1'b1;
        start1 = 1'b0;
        start4 = 1'b0;
        tick();
        check("post_rst_idle", 32'({busy1, busy4, mrst1, mrst4}), 32'd0);

        run_single(16'h0100, 16'h0040, 1'b0);
        run_single(16'h0100, 16'h0040, 1'b1);
        run_single(16'h0100, 16'h0040, 1'b0);

        cfg4_act = 16'h0200;
        cfg4_out = 16'h0800;
        start4   = 1'b1;
        c = 0;
        tick();
        start4 = 1'b0;
        for (c = 1; c <= 119; c++) begin
            check("g4_out_valid", 32'(ov4), 32'(c == 36 || c == 63 || c == 90 || c == 117));
            check("g4_done", 32'(done4), 32'(c == 118));
            check("g4_busy", 32'(busy4), 32'(c <= 117));
            if (c == 36 || c == 63 || c == 90 || c == 117) begin
                ea = 16'h0800 + 16'((c - 36) / 27);
                check("g4_out_addr", 32'(oa4), 32'(ea));
            end
            if (c == 30)
                check("g4_a_addr_g1", 32'(a_addr4), 32'h0201);
            if (c == 57)
                check("g4_a_addr_g2", 32'(a_addr4), 32'h0202);
            tick();
        end

        cfg1_act = 16'h0100;
        cfg1_out = 16'h0040;
        start1   = 1'b1;
        c = 0;
        tick();
        start1 = 1'b0;
        for (c = 1; c < 20; c++) tick();
        rst = 1'b0;
        tick();
        check("mid_rst_mac_rst", 32'(mrst1), 32'd0);
        check("mid_rst_busy", 32'(busy1), 32'd0);
        check("mid_rst_a_addr", 32'(a_addr1), 32'd0);
        rst  = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (ov1 || done1 || busy1) seen++;
            tick();
        end
        check("mid_rst_quiet", 32'(seen), 32'd0);

        run_single(16'h0100, 16'h0040, 1'b0);
        run_single(16'hFFFE, 16'h1234, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
